timer_irq_gen: RTL

- Machine-timer interrupt source: the requester side of the trap interface.
- Holds 64-bit mtime and mtimecmp registers, memory-mapped over the same addr/wdata/rd/wr style bus as the CSR file.
- Raises timer_irq, which drives the CSR file's trap input, and holds it under a request/acknowledge/mret handshake until the core has taken and returned from the trap.

---
 rtl/timer_irq_gen.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_irq_gen.sv
// -----------------------------------------------------------------------------
// timer_irq_gen
//
// Machine-timer interrupt source. Holds the 64-bit mtime counter and the
// 64-bit mtimecmp compare register, both memory-mapped on the simple
// addr/wdata/rd_en/wr_en bus shared with the CSR file. When mtime >= mtimecmp
// it raises timer_irq toward the CSR trap input. It keeps the request up
// through a request / acknowledge / mret handshake so the core always sees a
// stable trap source until it has returned from the handler.
//
// Register window (byte offsets from BASE_ADDR, 32-bit words):
//   +0x4000  mtimecmp[31:0]
//   +0x4004  mtimecmp[63:32]
//   +0x4008  reload (only with TIMER_AUTO_RELOAD_EN)
//   +0xBFF8  mtime[31:0]
//   +0xBFFC  mtime[63:32]
//   Any other address reads 0, and writes to it are dropped.
//
// Optional build macro:
//   TIMER_AUTO_RELOAD_EN - adds a 32-bit reload register. When the core
//   acknowledges a pending interrupt, the reload value is added to mtimecmp.
//   This gives a periodic tick without software rewriting mtimecmp.
//
// Parameters:
//   PRESCALE   clock cycles per mtime increment (1..65535)
//   BASE_ADDR  base byte address of the register window
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset
//   addr       byte address from the load/store path
//   wdata      store data
//   wr_en      write strobe, one cycle per write
//   rd_en      read strobe
//   rdata      combinational read data, 0 when rd_en is low
//   irq_ack    core has vectored to the trap
//   mret       MRET retiring
//   timer_irq  interrupt request to the CSR trap input
//   irq_state  handshake FSM state (00 idle, 01 pending, 10 in service)
// -----------------------------------------------------------------------------
module timer_irq_gen #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  input  logic        irq_ack,
  input  logic        mret,
  output logic        timer_irq,
  output logic [1:0]  irq_state
);

  // FSM encodings; 2'b11 is never entered and falls back to idle.
  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_PENDING    = 2'b01;
  localparam logic [1:0] ST_IN_SERVICE = 2'b10;

  // Register offsets inside the window.
  localparam logic [31:0] OFF_CMP_LO  = 32'h0000_4000;
  localparam logic [31:0] OFF_CMP_HI  = 32'h0000_4004;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam logic [31:0] OFF_RELOAD  = 32'h0000_4008;
`endif
  localparam logic [31:0] OFF_TIME_LO = 32'h0000_BFF8;
  localparam logic [31:0] OFF_TIME_HI = 32'h0000_BFFC;

  // Last value of the prescale counter before it wraps and mtime advances.
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] presc_q,    presc_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  state_q,    state_d;
  logic        irq_q,      irq_d;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [31:0] reload_q,   reload_d;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // A subtraction, not a bit-slice match, so BASE_ADDR need not be aligned
  // to the window size.
  logic [31:0] offset;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_time_lo;
  logic        wr_time_hi;
`ifdef TIMER_AUTO_RELOAD_EN
  logic        wr_reload;
`endif

  assign offset     = addr - BASE_ADDR;
  assign wr_cmp_lo  = wr_en && (offset == OFF_CMP_LO);
  assign wr_cmp_hi  = wr_en && (offset == OFF_CMP_HI);
  assign wr_time_lo = wr_en && (offset == OFF_TIME_LO);
  assign wr_time_hi = wr_en && (offset == OFF_TIME_HI);
`ifdef TIMER_AUTO_RELOAD_EN
  assign wr_reload  = wr_en && (offset == OFF_RELOAD);
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Reads come from the registered values, so a same-cycle write to the
  // same address returns the old contents.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        OFF_CMP_LO:  rdata = mtimecmp_q[31:0];
        OFF_CMP_HI:  rdata = mtimecmp_q[63:32];
`ifdef TIMER_AUTO_RELOAD_EN
        OFF_RELOAD:  rdata = reload_q;
`endif
        OFF_TIME_LO: rdata = mtime_q[31:0];
        OFF_TIME_HI: rdata = mtime_q[63:32];
        default:     rdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and mtime
  // ---------------------------------------------------------------------------
  logic tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = tick ? 16'd0 : (presc_q + 16'd1);
  end

  // A bus write to either half of mtime replaces that cycle's increment.
  // This stops a carry from the old value corrupting freshly written software
  // state. The prescaler still wraps normally, so the tick is simply lost.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_time_lo) begin
      mtime_d = {mtime_q[63:32], wdata};
    end else if (wr_time_hi) begin
      mtime_d = {wdata, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and handshake FSM
  // ---------------------------------------------------------------------------
  logic hit;
  logic take;

  assign hit  = (mtime_q >= mtimecmp_q);
  assign take = (state_q == ST_PENDING) && irq_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // The acknowledge wins over a withdrawn compare: once the core has
        // vectored, the trap must be seen through to mret.
        if (irq_ack)  state_d = ST_IN_SERVICE;
        else if (!hit) state_d = ST_IDLE;
      end
      ST_IN_SERVICE: begin
        if (mret) state_d = hit ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The request is registered from the next state, so it is glitch-free and
  // lines up exactly with irq_state.
  always_comb begin
    irq_d = (state_d == ST_PENDING) || (state_d == ST_IN_SERVICE);
  end

  // ---------------------------------------------------------------------------
  // mtimecmp (and optional auto-reload)
  // ---------------------------------------------------------------------------
`ifdef TIMER_AUTO_RELOAD_EN
  always_comb begin
    reload_d = wr_reload ? wdata : reload_q;
  end

  // A software write to either compare half overrides the reload step.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d = {mtimecmp_q[63:32], wdata};
    end else if (wr_cmp_hi) begin
      mtimecmp_d = {wdata, mtimecmp_q[31:0]};
    end else if (take) begin
      mtimecmp_d = mtimecmp_q + {32'd0, reload_q};
    end
  end
`else
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d = {mtimecmp_q[63:32], wdata};
    end else if (wr_cmp_hi) begin
      mtimecmp_d = {wdata, mtimecmp_q[31:0]};
    end
  end

  // The acknowledge only steers the FSM in this build.
  logic take_unused;
  assign take_unused = take;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      state_q    <= ST_IDLE;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      state_q    <= state_d;
      irq_q      <= irq_d;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign timer_irq = irq_q;
  assign irq_state = state_q;

endmodule
